// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store front end: access sizes, FSM states,
// default memory depth and the alignment rule used when trapping is enabled.
package lsu_pkg;

  localparam int DEF_WORD_ADDR_W = 7;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    IDLE,
    WRITE
  } lsuState_t;

  // Size 2'b11 behaves as a word, so anything not byte/half needs a clean word offset.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: isMisaligned = 1'b0;
      SZ_HALF: isMisaligned = lane[0];
      default: isMisaligned = (lane != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: picks and extends the load lane out of a memory
// word, and merges right-aligned store data into a memory word at the lane.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  output logic [31:0] loadData,
  output logic [31:0] mergedData
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;
  logic        signBit;

  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    selByte    = rdata[{lane, 3'b000} +: 8];
    selHalf    = lane[1] ? rdata[31:16] : rdata[15:0];
    signBit    = 1'b0;
    loadData   = rdata;
    mergedData = rdata;

    case (size)
      SZ_BYTE: begin
        signBit  = ~isUnsigned & selByte[7];
        loadData = {{24{signBit}}, selByte};
        mergedData[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        signBit  = ~isUnsigned & selHalf[15];
        loadData = {{16{signBit}}, selHalf};
        if (lane[1]) mergedData[31:16] = wdata[15:0];
        else         mergedData[15:0]  = wdata[15:0];
      end
      default: begin
        loadData   = rdata;
        mergedData = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-addressed data memory: sub-word stores become
// a stalled read-modify-write. Optional feature macro: LSU_MISALIGN_TRAP_EN.
module mem_access_unit
  import lsu_pkg::*;
#(
  parameter int WORD_ADDR_W = DEF_WORD_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misalign_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);

  lsuState_t              state, stateNext;
  logic [31:0]            wbuf, wbufNext;
  logic [WORD_ADDR_W-1:0] abuf, abufNext;

  logic [WORD_ADDR_W-1:0] wordIndex;
  logic                   misaligned;
  logic                   accept;
  logic [31:0]            alignedLoad;
  logic [31:0]            mergedWord;

  // Upper address bits are dropped on purpose: accesses wrap modulo memory size.
  assign wordIndex = req_addr[WORD_ADDR_W+1:2];

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalignFlag;

  assign misaligned   = isMisaligned(req_size, req_addr[1:0]);
  assign misalign_err = misalignFlag;

  always_ff @(posedge clk) begin
    if (rst)
      misalignFlag <= 1'b0;
    else if (state == IDLE && req_valid && misaligned)
      misalignFlag <= 1'b1;
  end
`else
  assign misaligned   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign accept = req_valid && !misaligned;

  lsu_align u_align (
    .rdata      (mem_rdata),
    .size       (req_size),
    .isUnsigned (req_unsigned),
    .lane       (req_addr[1:0]),
    .wdata      (req_wdata),
    .loadData   (alignedLoad),
    .mergedData (mergedWord)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wbuf  <= '0;
      abuf  <= '0;
    end else begin
      state <= stateNext;
      wbuf  <= wbufNext;
      abuf  <= abufNext;
    end
  end

  always_comb begin
    stateNext = state;
    wbufNext  = wbuf;
    abufNext  = abuf;
    load_data = '0;
    stall     = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;

    // While reset is held every output stays at its zero default, which also
    // drops a write still pending from WRITE.
    if (!rst) begin
      case (state)
        IDLE: begin
          if (accept) begin
            mem_addr = {{(32-WORD_ADDR_W){1'b0}}, wordIndex};
            if (!req_we) begin
              mem_read  = 1'b1;
              load_data = alignedLoad;
            end else if (req_size[1]) begin
              mem_write = 1'b1;
              mem_wdata = req_wdata;
            end else begin
              mem_read  = 1'b1;
              stall     = 1'b1;
              wbufNext  = mergedWord;
              abufNext  = wordIndex;
              stateNext = WRITE;
            end
          end
        end
        WRITE: begin
          // The core still holds the stalled store on req_*; it is not re-decoded.
          mem_addr  = {{(32-WORD_ADDR_W){1'b0}}, abuf};
          mem_wdata = wbuf;
          mem_write = 1'b1;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: per-cycle expectations are queued as
// stimulus is driven and compared at the falling edge against a behavioural memory.
module tb_mem_access_unit;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqUnsigned = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [31:0] loadData;
  logic        stall;
  logic        misalignErr;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memRdata;

  logic [31:0] memArr [128];

  typedef struct {
    string       name;
    logic [31:0] ld;
    logic        st;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        dc;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  exp_t mon;
  logic expErr = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (reqValid),
    .req_we       (reqWe),
    .req_size     (reqSize),
    .req_unsigned (reqUnsigned),
    .req_addr     (reqAddr),
    .req_wdata    (reqWdata),
    .load_data    (loadData),
    .stall        (stall),
    .misalign_err (misalignErr),
    .mem_addr     (memAddr),
    .mem_wdata    (memWdata),
    .mem_write    (memWrite),
    .mem_read     (memRead),
    .mem_rdata    (memRdata)
  );

  // Behavioural data memory: combinational read, commit on the falling edge.
  assign memRdata = memArr[memAddr[6:0]];
  always @(negedge clk) if (memWrite) memArr[memAddr[6:0]] <= memWdata;

  // Scoreboard consumer: outputs are stable mid-cycle, before the memory commit lands.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      mon = expQ.pop_front();
      vectors += 4;
      if (loadData !== mon.ld) begin
        miscompares++; $display("FAIL %s.load_data: got %h, want %h", mon.name, loadData, mon.ld);
      end
      if (stall !== mon.st) begin
        miscompares++; $display("FAIL %s.stall: got %b, want %b", mon.name, stall, mon.st);
      end
      if (memWrite !== mon.wr) begin
        miscompares++; $display("FAIL %s.mem_write: got %b, want %b", mon.name, memWrite, mon.wr);
      end
      if (misalignErr !== mon.err) begin
        miscompares++; $display("FAIL %s.misalign_err: got %b, want %b", mon.name, misalignErr, mon.err);
      end
      if (!mon.dc) begin
        vectors += 3;
        if (memRead !== mon.rd) begin
          miscompares++; $display("FAIL %s.mem_read: got %b, want %b", mon.name, memRead, mon.rd);
        end
        if (memAddr !== mon.addr) begin
          miscompares++; $display("FAIL %s.mem_addr: got %h, want %h", mon.name, memAddr, mon.addr);
        end
        if (memWdata !== mon.wd) begin
          miscompares++; $display("FAIL %s.mem_wdata: got %h, want %h", mon.name, memWdata, mon.wd);
        end
      end
    end
  end

  // One clock of stimulus plus the outputs the spec demands for it.
  task automatic cyc(input string nm, input logic r, v, we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, wd, eLd, input logic eSt, eWr, eRd,
                     input logic [31:0] eAddr, eWd, input logic dc = 1'b0);
    exp_t e;
    @(posedge clk); #1;
    rst = r; reqValid = v; reqWe = we; reqSize = sz; reqUnsigned = uns;
    reqAddr = a; reqWdata = wd;
    e = '{nm, eLd, eSt, eWr, eRd, eAddr, eWd, dc, expErr};
    expQ.push_back(e);
  endtask

  task automatic wordStore(input string nm, input logic [31:0] a, d, input logic [31:0] idx);
    cyc(nm, 0, 1, 1, W, 0, a, d, 0, 0, 1, 0, idx, d);
  endtask

  task automatic idle(input string nm);
    cyc(nm, 0, 0, 0, W, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic memCheck(input string nm, input int idx, input logic [31:0] want);
    @(negedge clk); #1;
    vectors++;
    if (memArr[idx] !== want) begin
      miscompares++; $display("FAIL %s.mem[%0d]: got %h, want %h", nm, idx, memArr[idx], want);
    end
  endtask

  task automatic test_reset();
    cyc("rst_forced", 1, 1, 1, W, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    idle("rst_idle");
  endtask

  task automatic test_word_access();
    wordStore("word_st", 32'h10, 32'hDEADBEEF, 4);
    cyc("word_ld", 0, 1, 0, W, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1, 4, 0);
    cyc("size3_ld", 0, 1, 0, 2'b11, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 1, 4, 0);
    memCheck("word_st", 4, 32'hDEADBEEF);
  endtask

  task automatic test_subword_store();
    wordStore("pre4", 32'h10, 32'h11223344, 4);
    cyc("byte_rmw_c0", 0, 1, 1, B, 0, 32'h11, 32'h123456AA, 0, 1, 0, 1, 4, 0);
    cyc("byte_rmw_c1", 0, 1, 1, B, 0, 32'h11, 32'h123456AA, 0, 0, 1, 0, 4, 32'h1122AA44);
    memCheck("byte_rmw", 4, 32'h1122AA44);
    wordStore("pre5", 32'h14, 32'h55667788, 5);
    cyc("half_rmw_c0", 0, 1, 1, H, 0, 32'h16, 32'h0000BEEF, 0, 1, 0, 1, 5, 0);
    cyc("half_rmw_c1", 0, 1, 1, H, 0, 32'h16, 32'h0000BEEF, 0, 0, 1, 0, 5, 32'hBEEF7788);
    cyc("half_rmw_ld", 0, 1, 0, W, 0, 32'h14, 32'h0, 32'hBEEF7788, 0, 0, 1, 5, 0);
  endtask

  task automatic test_load_extend();
    wordStore("pre_ext", 32'h10, 32'h80223344, 4);
    cyc("lb13_s",  0, 1, 0, B, 0, 32'h13, 0, 32'hFFFFFF80, 0, 0, 1, 4, 0);
    cyc("lb13_u",  0, 1, 0, B, 1, 32'h13, 0, 32'h00000080, 0, 0, 1, 4, 0);
    cyc("lh12_s",  0, 1, 0, H, 0, 32'h12, 0, 32'hFFFF8022, 0, 0, 1, 4, 0);
    cyc("lh12_u",  0, 1, 0, H, 1, 32'h12, 0, 32'h00008022, 0, 0, 1, 4, 0);
    cyc("lh10_s",  0, 1, 0, H, 0, 32'h10, 0, 32'h00003344, 0, 0, 1, 4, 0);
    cyc("lb11_s",  0, 1, 0, B, 0, 32'h11, 0, 32'h00000033, 0, 0, 1, 4, 0);
    cyc("lb10_u",  0, 1, 0, B, 1, 32'h10, 0, 32'h00000044, 0, 0, 1, 4, 0);
    idle("no_valid");
  endtask

  task automatic test_wrap();
    wordStore("pre0", 32'h0, 32'hAAAAAAAA, 0);
    cyc("wrap_c0", 0, 1, 1, H, 0, 32'h200, 32'h00001234, 0, 1, 0, 1, 0, 0);
    cyc("wrap_c1", 0, 1, 1, H, 0, 32'h200, 32'h00001234, 0, 0, 1, 0, 0, 32'hAAAA1234);
    memCheck("wrap", 0, 32'hAAAA1234);
    cyc("wrap_ld", 0, 1, 0, W, 0, 32'h210, 0, 32'h80223344, 0, 0, 1, 4, 0);
  endtask

  task automatic test_back_to_back();
    wordStore("pre8", 32'h20, 32'h0, 8);
    cyc("b2b_a_c0", 0, 1, 1, B, 0, 32'h23, 32'h7F, 0, 1, 0, 1, 8, 0);
    cyc("b2b_a_c1", 0, 1, 1, B, 0, 32'h23, 32'h7F, 0, 0, 1, 0, 8, 32'h7F000000);
    cyc("b2b_b_c0", 0, 1, 1, B, 0, 32'h20, 32'h01, 0, 1, 0, 1, 8, 0);
    cyc("b2b_b_c1", 0, 1, 1, B, 0, 32'h20, 32'h01, 0, 0, 1, 0, 8, 32'h7F000001);
    cyc("b2b_ld",   0, 1, 0, B, 0, 32'h23, 0, 32'h0000007F, 0, 0, 1, 8, 0);
  endtask

  task automatic test_reset_in_write();
    wordStore("pre7", 32'h1C, 32'h01020304, 7);
    cyc("rw_c0",  0, 1, 1, B, 0, 32'h1C, 32'hFF, 0, 1, 0, 1, 7, 0);
    cyc("rw_rst", 1, 1, 1, B, 0, 32'h1C, 32'hFF, 0, 0, 0, 0, 0, 0);
    idle("rw_idle");
    memCheck("rw_dropped", 7, 32'h01020304);
    cyc("rw_ld", 0, 1, 0, W, 0, 32'h1C, 0, 32'h01020304, 0, 0, 1, 7, 0);
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    wordStore("pre1", 32'h4, 32'h0BADF00D, 1);
    cyc("mis_word", 0, 1, 1, W, 0, 32'h6, 32'h55AA55AA, 0, 0, 0, 0, 0, 0, 1'b1);
    expErr = 1'b1;
    idle("mis_sticky");
    cyc("mis_half", 0, 1, 1, H, 0, 32'h13, 32'hCAFE, 0, 0, 0, 0, 0, 0, 1'b1);
    cyc("mis_hold_ld", 0, 1, 0, W, 0, 32'h4, 0, 32'h0BADF00D, 0, 0, 1, 1, 0);
    memCheck("mis_nowrite", 1, 32'h0BADF00D);
`else
    wordStore("mis_word", 32'h6, 32'h55AA55AA, 1);
    wordStore("pre4z", 32'h10, 32'h0, 4);
    cyc("mis_half_c0", 0, 1, 1, H, 0, 32'h13, 32'hCAFE, 0, 1, 0, 1, 4, 0);
    cyc("mis_half_c1", 0, 1, 1, H, 0, 32'h13, 32'hCAFE, 0, 0, 1, 0, 4, 32'hCAFE0000);
    memCheck("mis_floor", 1, 32'h55AA55AA);
`endif
    cyc("mis_rst", 1, 0, 0, W, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    expErr = 1'b0;
    idle("mis_cleared");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_word_access();
    test_subword_store();
    test_load_extend();
    test_wrap();
    test_back_to_back();
    test_reset_in_write();
    test_misalign();
    repeat (2) @(posedge clk);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++; $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
